// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux scheduler.
package mux4_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        onehot = N_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] pick
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        idx  = '0;
        any  = |req;
        pick = '0;
        // Walk from lowest to highest priority so the nearest hit after 'last' wins.
        for (int i = N_REQ; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux channel, with per-grant beat cap.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] I,
    input  logic             y_ready,
    output logic [SEL_W-1:0] S,
    output logic [N_REQ-1:0] gnt,
    output logic             Y,
    output logic             y_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             granted;
    logic             accept;
    logic             release_grant;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] pick_last;

    assign granted       = (state_q == GRANT);
    assign accept        = granted && req[s_q] && y_ready;
    assign release_grant = granted && (!req[s_q] || (accept && (cnt_q == LAST_BEAT)));

    // On release the owner becomes 'last' in the same cycle, so rotate from it directly.
    assign pick_last = granted ? s_q : last_q;

    rr_pick4 u_pick (
        .req  (req),
        .last (pick_last),
        .any  (pick_any),
        .pick (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    s_d     = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_d = s_q;
                    cnt_d  = '0;
                    if (pick_any) begin
                        s_d   = pick_idx;
                        gnt_d = onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        S       = s_q;
        gnt     = gnt_q;
        busy    = granted;
        y_valid = granted && req[s_q];
        Y       = granted ? I[s_q] : 1'b0;
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: reset, hold cap, fairness, stalls, withdrawal.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] I;
    logic       y_ready;

    logic [1:0] S,  S1;
    logic [3:0] gnt, gnt1;
    logic       Y, Y1, y_valid, y_valid1, busy, busy1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .I(I), .y_ready(y_ready),
        .S(S), .gnt(gnt), .Y(Y), .y_valid(y_valid), .busy(busy)
    );

    mux4_rr_sched #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .I(I), .y_ready(y_ready),
        .S(S1), .gnt(gnt1), .Y(Y1), .y_valid(y_valid1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n   = 1'b0;
        req     = r;
        y_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        I       = 4'b0000;
        y_ready = 1'b1;

        // Reset held with all requesting
        step(); step(); step();
        chk("rst_gnt",     8'(gnt), 8'h0);
        chk("rst_S",       8'(S), 8'h0);
        chk("rst_y_valid", 8'(y_valid), 8'h0);
        chk("rst_busy",    8'(busy), 8'h0);
        chk("rst_Y",       8'(Y), 8'h0);

        // Single requester, re-grant with no idle bubble
        do_reset(4'b0000);
        req = 4'b0100;
        I   = 4'b0100;
        step();
        chk("single_gnt",     8'(gnt), 8'h04);
        chk("single_S",       8'(S), 8'h2);
        chk("single_Y",       8'(Y), 8'h1);
        chk("single_y_valid", 8'(y_valid), 8'h1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("single_busy_%0d", c), 8'(busy), 8'h1);
            chk($sformatf("single_gnt_%0d", c), 8'(gnt), 8'h04);
        end

        // Fairness, all requesting, 4 beats per grant
        do_reset(4'b0000);
        req = 4'b1111;
        I   = 4'b1010;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("fair_S_%0d", c), 8'(S), 8'((c / 4) % 4));
            chk($sformatf("fair_Y_%0d", c), 8'(Y), 8'((c / 4) % 2));
        end

        // Backpressure on owner 1; stalls must not consume the budget
        do_reset(4'b0000);
        req = 4'b0010;
        I   = 4'b0000;
        step();
        chk("bp_S_grant", 8'(S), 8'h1);
        req = 4'b0011;
        step();
        step();
        y_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_stall_S_%0d", c), 8'(S), 8'h1);
            chk($sformatf("bp_stall_vld_%0d", c), 8'(y_valid), 8'h1);
            step();
        end
        y_ready = 1'b1;
        chk("bp_resume_S0", 8'(S), 8'h1);
        step();
        chk("bp_resume_S1", 8'(S), 8'h1);
        step();
        chk("bp_rotate_S",   8'(S), 8'h0);
        chk("bp_rotate_gnt", 8'(gnt), 8'h01);

        // Withdrawal to another requester
        do_reset(4'b0000);
        req = 4'b1001;
        I   = 4'b1111;
        step();
        chk("wd_S0", 8'(S), 8'h0);
        step();
        step();
        req = 4'b1000;
        #1;
        chk("wd_y_valid_drop", 8'(y_valid), 8'h0);
        step();
        chk("wd_gnt", 8'(gnt), 8'h08);
        chk("wd_S",   8'(S), 8'h3);

        // Withdrawal with nobody left
        do_reset(4'b0000);
        req = 4'b1001;
        step();
        step();
        step();
        req = 4'b0000;
        step();
        chk("wd_idle_gnt",  8'(gnt), 8'h0);
        chk("wd_idle_busy", 8'(busy), 8'h0);
        chk("wd_idle_Y",    8'(Y), 8'h0);
        chk("wd_idle_S",    8'(S), 8'h0);

        // Asynchronous reset mid-grant
        do_reset(4'b0000);
        req = 4'b0100;
        step();
        chk("ar_pre_gnt", 8'(gnt), 8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt",  8'(gnt), 8'h0);
        chk("ar_busy", 8'(busy), 8'h0);
        chk("ar_S",    8'(S), 8'h0);
        chk("ar_Y",    8'(Y), 8'h0);

        // HOLD_MAX=1: strict alternation
        do_reset(4'b0000);
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("h1_S_%0d", c), 8'(S1), 8'(c % 2));
            chk($sformatf("h1_busy_%0d", c), 8'(busy1), 8'h1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 mux channel (I[3:0] -> Y, select S[1:0]) among four requesters.
- Arbitrates the request lines and drives S and a one-hot grant.
- Presents the selected bit downstream with a valid/ready handshake.
- Caps each grant at HOLD_MAX accepted beats so no requester can starve the others.

Parameters:
- HOLD_MAX, 4, maximum accepted beats per grant before forced rotation. Legal range 1..255.
- CNT_W, 8, width of the beat counter. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester; bit k is requester k.
- I  in  4  data bit per requester; mux data inputs.
- y_ready  in  1  downstream accepts Y this cycle.
- S  out  2  mux select, equals current owner index. Registered.
- gnt  out  4  one-hot grant to owner, all-zero when idle. Registered.
- Y  out  1  I[S] while granted, else 0. Combinational from I and S.
- y_valid  out  1  high in GRANT while req[S] is high.
- busy  out  1  high in GRANT.

Behaviour:
- Reset, asynchronous assert:
  - state=IDLE, S=0, gnt=0, last=3 (so requester 0 has first priority), cnt=0.
  - Outputs: Y=0, y_valid=0, busy=0.
- Reset release is synchronous to clk.
- Reset mid-grant aborts the grant immediately. No beat is accepted in the reset cycle.
- Priority search: start at index (last+1) mod 4 and wrap; pick the first k with req[k]=1.
- State IDLE:
  - If any req bit is set: next edge sets owner=pick, S=pick, gnt=1<<pick, cnt=0, state=GRANT.
  - Grant latency from req rise to gnt is 1 cycle.
  - If req=0: stay in IDLE.
- State GRANT:
  - Beat accepted when y_valid && y_ready. On acceptance, cnt increments.
  - Release when either:
    - (a) accepted beat with cnt==HOLD_MAX-1, or
    - (b) req[owner]==0 (owner withdrew, no beat that cycle).
  - On release: last=owner and re-arbitrate in the same cycle, excluding nothing.
    - If some req is set (masked per (b): requester withdrawing is 0 anyway), next edge grants pick with cnt=0. No idle bubble.
    - Otherwise go to IDLE with gnt=0, S held at old value, Y=0.
  - Re-grant to the same requester is allowed when it is the only requester. cnt restarts at 0.
  - y_ready low: hold owner, S and cnt. The HOLD_MAX budget counts accepted beats only, never stall cycles.
- Simultaneous events:
  - Owner drops req in the same cycle another requester raises req: the new requester wins per rotation from last=owner.
  - Requests arriving mid-grant do not pre-empt the current owner.
- Outputs S and gnt change only on clk edges. Y follows I combinationally within a cycle.
- gnt is always one-hot or zero. S==index(gnt) whenever gnt!=0.
- Widths: cnt is unsigned CNT_W. Compare against HOLD_MAX-1 at CNT_W bits. No overflow is possible under the legal range.

Decomposition:
- Package mux4_sched_pkg holds:
  - N_REQ=4 and SEL_W=2.
  - State enum {IDLE, GRANT}.
  - Function onehot(sel) returning 4-bit one-hot.
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], last[1:0].
  - Outputs: any, pick[1:0].
  - Instantiated once. Reused by IDLE and release paths.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, S=0, y_valid=0, busy=0. Assert rst_n=0 mid-grant -> gnt=0 in the same cycle without waiting for an edge.
- Single requester: req=4'b0100, I=4'b0100, y_ready=1 -> one edge later gnt=4'b0100, S=2, Y=1, y_valid=1.
  - After 4 accepted beats, re-granted to 2 with cnt=0 and no cycle where busy=0.
- Fairness: req=4'b1111, HOLD_MAX=4, y_ready=1 -> grant order 0,1,2,3,0. Each grant lasts exactly 4 cycles. Output is S=0,0,0,0,1,1,1,1,...
- Backpressure: owner 1, y_ready low for 5 cycles mid-grant -> S stays 1, cnt frozen, y_valid=1. After y_ready returns, exactly the remaining beats are accepted before rotation.
- Withdrawal: owner 0 with req=4'b1001, drop req[0] after 2 beats -> next edge gnt=4'b1000, S=3. If req becomes 4'b0000 instead, state=IDLE, gnt=0, Y=0.
- HOLD_MAX=1 with req=4'b0011 -> strict alternation of S: 0,1,0,1 every accepted beat.
